axi_light_master: RTL and testbench

// - AXI-lite initiator: counterpart of the AXI-lite slave to BRAM controller.
// - Turns single-beat native memory requests (read/write, byte strobes, done pulse) into
//   AXI-lite transactions, for cores, DMA or debug units on the AXI-lite fabric.
// - One transaction in flight; returns read data and error status on completion.

---
 rtl/axi_light_master.sv | 200 ++++++++++++++++++++
 tb/tb_axi_light_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_light_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_light_master
// Purpose  : AXI-lite initiator. Converts single-beat native memory requests
//            (read/write with byte strobes) into AXI-lite transactions, with
//            one transaction in flight, and reports completion through a
//            one-cycle done pulse carrying read data and error status.
// Ports    : clk, res_n                  clock / async active-low reset
//            mem_read, mem_write          request strobes (sampled in IDLE)
//            mem_addr/wdata/wstrb         request payload (latched)
//            mem_rdata/done/error         completion interface
//            m_axi_aw*, m_axi_w*, m_axi_b* AXI-lite write channels
//            m_axi_ar*, m_axi_r*          AXI-lite read channels
// Revision : 1.0  initial release
// ============================================================================
module axi_light_master #(
  parameter int              ADDR_WIDTH = 32,
  parameter int              DATA_WIDTH = 32,
  parameter logic [2:0]      PROT       = 3'b000
) (
  input  logic                    clk,
  input  logic                    res_n,
  // native request side
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_done,
  output logic                    mem_error,
  // write address channel
  output logic                    m_axi_awvalid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  input  logic                    m_axi_awready,
  // write data channel
  output logic                    m_axi_wvalid,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                    m_axi_wready,
  // write response channel
  input  logic                    m_axi_bvalid,
  input  logic [1:0]              m_axi_bresp,
  output logic                    m_axi_bready,
  // read address channel
  output logic                    m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  input  logic                    m_axi_arready,
  // read data channel
  input  logic                    m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    DONE         = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    w_aw_next;
  logic                    w_w_next;
  logic                    w_err_next;

  // A channel counts as finished once its valid has dropped, or when its
  // handshake happens in the current cycle.
  logic w_aw_finished;
  logic w_w_finished;
  assign w_aw_finished = !m_axi_awvalid || m_axi_awready;
  assign w_w_finished  = !m_axi_wvalid  || m_axi_wready;

  assign m_axi_awaddr = r_addr;
  assign m_axi_araddr = r_addr;
  assign m_axi_awprot = PROT;
  assign m_axi_arprot = PROT;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (mem_write) begin
          w_state_next = WR_ADDR_DATA;
        end else if (mem_read) begin
          w_state_next = RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        if (w_aw_finished && w_w_finished) begin
          w_state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          w_state_next = DONE;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          w_state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered output values. Each valid is raised on request acceptance and
  // held until its own handshake; nothing depends combinationally on ready.
  // --------------------------------------------------------------------------
  always_comb begin
    w_aw_next  = 1'b0;
    w_w_next   = 1'b0;
    w_err_next = 1'b0;
    if (r_state == IDLE && mem_write) begin
      w_aw_next = 1'b1;
      w_w_next  = 1'b1;
    end else if (r_state == WR_ADDR_DATA) begin
      w_aw_next = m_axi_awvalid && !m_axi_awready;
      w_w_next  = m_axi_wvalid  && !m_axi_wready;
    end
    // Error flag is only ever non-zero in the cycle that enters DONE, so
    // mem_error reads as 0 outside the done pulse.
    if (r_state == WR_RESP && m_axi_bvalid) begin
      w_err_next = (m_axi_bresp != 2'b00);
    end else if (r_state == RD_DATA && m_axi_rvalid) begin
      w_err_next = (m_axi_rresp != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      mem_done      <= 1'b0;
      mem_error     <= 1'b0;
      r_addr        <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      mem_rdata     <= '0;
    end else begin
      m_axi_awvalid <= w_aw_next;
      m_axi_wvalid  <= w_w_next;
      m_axi_bready  <= (w_state_next == WR_RESP);
      m_axi_arvalid <= (w_state_next == RD_ADDR);
      m_axi_rready  <= (w_state_next == RD_DATA);
      mem_done      <= (w_state_next == DONE);
      mem_error     <= w_err_next;

      if (r_state == IDLE && (mem_write || mem_read)) begin
        r_addr <= mem_addr;
      end
      if (r_state == IDLE && mem_write) begin
        m_axi_wdata <= mem_wdata;
        m_axi_wstrb <= mem_wstrb;
      end
      // Read data is kept after completion; write completions leave it alone.
      if (r_state == RD_DATA && m_axi_rvalid) begin
        mem_rdata <= m_axi_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_light_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_light_master
// Purpose  : Self-checking bench for axi_light_master. A behavioural AXI-lite
//            slave with per-channel ready/response delays, a table of
//            transactions with hand-computed latency/data/error, and a
//            hand-written reset-during-transaction sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_light_master;

  logic        clk = 1'b0;
  logic        res_n;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_done, mem_error;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic [1:0]  bresp, rresp;

  axi_light_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000)) dut (
    .clk(clk), .res_n(res_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_error(mem_error),
    .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_awready(awready),
    .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wready(wready),
    .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_arready(arready),
    .m_axi_rvalid(rvalid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchecks = 0;
  int nerrors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Slave model configuration and observation
  // --------------------------------------------------------------------------
  int          cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
  logic [1:0]  cfg_resp;
  logic [31:0] cfg_sdata;

  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int aw_hs, w_hs, b_hs, ar_hs, r_hs, stab;
  logic        aw_pend, w_pend, ar_pend;
  logic [31:0] aw_prev, w_prev, ar_prev;
  logic [3:0]  s_prev;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_prot;

  task automatic slave_step();
    if (!res_n) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_pend = 0; w_pend = 0; ar_pend = 0;
    end else begin
      // write address
      if (awvalid) begin
        if (aw_pend && awaddr !== aw_prev) stab++;
        awready = (aw_cnt >= cfg_aw_d);
        aw_cnt++;
        if (awready) begin
          aw_hs++; cap_awaddr = awaddr; cap_prot = awprot; aw_pend = 0;
        end else begin
          aw_pend = 1; aw_prev = awaddr;
        end
      end else begin
        if (aw_pend) stab++;
        aw_pend = 0; awready = 0; aw_cnt = 0;
      end
      // write data
      if (wvalid) begin
        if (w_pend && (wdata !== w_prev || wstrb !== s_prev)) stab++;
        wready = (w_cnt >= cfg_w_d);
        w_cnt++;
        if (wready) begin
          w_hs++; cap_wdata = wdata; cap_wstrb = wstrb; w_pend = 0;
        end else begin
          w_pend = 1; w_prev = wdata; s_prev = wstrb;
        end
      end else begin
        if (w_pend) stab++;
        w_pend = 0; wready = 0; w_cnt = 0;
      end
      // read address
      if (arvalid) begin
        if (ar_pend && araddr !== ar_prev) stab++;
        arready = (ar_cnt >= cfg_ar_d);
        ar_cnt++;
        if (arready) begin
          ar_hs++; cap_araddr = araddr; ar_pend = 0;
        end else begin
          ar_pend = 1; ar_prev = araddr;
        end
      end else begin
        if (ar_pend) stab++;
        ar_pend = 0; arready = 0; ar_cnt = 0;
      end
      // write response
      if (bready) begin
        bvalid = (b_cnt >= cfg_b_d); bresp = cfg_resp; b_cnt++;
        if (bvalid) b_hs++;
      end else begin
        bvalid = 0; b_cnt = 0;
      end
      // read data
      if (rready) begin
        rvalid = (r_cnt >= cfg_r_d); rresp = cfg_resp; rdata = cfg_sdata; r_cnt++;
        if (rvalid) r_hs++;
      end else begin
        rvalid = 0; r_cnt = 0;
      end
    end
  endtask

  initial begin
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0;
    forever begin
      @(negedge clk);
      slave_step();
    end
  end

  // --------------------------------------------------------------------------
  // Transaction table
  // --------------------------------------------------------------------------
  typedef struct {
    logic        wr, rd;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    logic [31:0] sdata;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic run_txn(input int i);
    vec_t v;
    int   t0, lat;
    logic done;
    v = vecs[i];
    cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_b_d = v.b_d;
    cfg_ar_d = v.ar_d; cfg_r_d = v.r_d; cfg_resp = v.resp; cfg_sdata = v.sdata;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; stab = 0;
    @(posedge clk); #1;
    mem_write = v.wr; mem_read = v.rd;
    mem_addr = v.addr; mem_wdata = v.wdata; mem_wstrb = v.strb;
    t0 = cyc;
    @(posedge clk); #1;
    mem_write = 0; mem_read = 0;
    mem_addr = ~v.addr; mem_wdata = ~v.wdata; mem_wstrb = ~v.strb;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (mem_done) done = 1;
    end
    lat = cyc - t0;
    check($sformatf("v%0d done_seen", i), done, 1'b1);
    check($sformatf("v%0d latency", i), lat, v.exp_lat);
    check($sformatf("v%0d mem_error", i), mem_error, v.exp_err);
    check($sformatf("v%0d mem_rdata", i), mem_rdata, v.exp_rdata);
    check($sformatf("v%0d aw_count", i), aw_hs, v.wr ? 1 : 0);
    check($sformatf("v%0d w_count", i), w_hs, v.wr ? 1 : 0);
    check($sformatf("v%0d b_count", i), b_hs, v.wr ? 1 : 0);
    check($sformatf("v%0d ar_count", i), ar_hs, (!v.wr && v.rd) ? 1 : 0);
    check($sformatf("v%0d r_count", i), r_hs, (!v.wr && v.rd) ? 1 : 0);
    check($sformatf("v%0d stability", i), stab, 0);
    if (v.wr) begin
      check($sformatf("v%0d awaddr", i), cap_awaddr, v.addr);
      check($sformatf("v%0d wdata", i), cap_wdata, v.wdata);
      check($sformatf("v%0d wstrb", i), cap_wstrb, v.strb);
      check($sformatf("v%0d awprot", i), cap_prot, 3'b000);
    end else begin
      check($sformatf("v%0d araddr", i), cap_araddr, v.addr);
    end
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", i), mem_done, 1'b0);
    check($sformatf("v%0d error_cleared", i), mem_error, 1'b0);
  endtask

  initial begin
    //        wr rd  addr          wdata         strb  aw w  b  ar r  resp   sdata         lat err rdata
    vecs[0] = '{1, 0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,         3, 0, 32'h0};
    vecs[1] = '{0, 1, 32'h0000_1004, 32'h0,         4'h0, 0, 0, 0, 5, 0, 2'b00, 32'h1234_5678, 8, 0, 32'h1234_5678};
    vecs[2] = '{1, 0, 32'h0000_2000, 32'hA5A5_5A5A, 4'h5, 0, 4, 0, 0, 0, 2'b00, 32'h0,         7, 0, 32'h1234_5678};
    vecs[3] = '{1, 1, 32'h0000_3000, 32'h0BAD_F00D, 4'hF, 0, 0, 2, 0, 0, 2'b00, 32'h0,         5, 0, 32'h1234_5678};
    vecs[4] = '{0, 1, 32'h0000_4000, 32'h0,         4'h0, 0, 0, 0, 0, 1, 2'b10, 32'hCAFE_BABE, 4, 1, 32'hCAFE_BABE};
    vecs[5] = '{1, 0, 32'h0000_5000, 32'h0000_0001, 4'h1, 0, 0, 0, 0, 0, 2'b00, 32'h0,         3, 0, 32'hCAFE_BABE};
    vecs[6] = '{1, 0, 32'h0000_5004, 32'h7777_8888, 4'hC, 3, 1, 0, 0, 0, 2'b11, 32'h0,         6, 1, 32'hCAFE_BABE};
    vecs[7] = '{0, 1, 32'h0000_5008, 32'h0,         4'h0, 0, 0, 0, 0, 2, 2'b01, 32'h0F0F_0F0F, 5, 1, 32'h0F0F_0F0F};
    vecs[8] = '{0, 1, 32'h0000_6000, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h600D_F00D, 3, 0, 32'h600D_F00D};

    res_n = 0; mem_read = 0; mem_write = 0;
    mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0;
    cfg_resp = 0; cfg_sdata = 0;
    repeat (3) @(posedge clk);
    #2;
    check("reset awvalid", awvalid, 1'b0);
    check("reset wvalid", wvalid, 1'b0);
    check("reset bready", bready, 1'b0);
    check("reset arvalid", arvalid, 1'b0);
    check("reset rready", rready, 1'b0);
    check("reset mem_done", mem_done, 1'b0);
    check("reset mem_error", mem_error, 1'b0);
    check("reset mem_rdata", mem_rdata, 32'h0);
    check("reset awaddr", awaddr, 32'h0);
    check("reset wdata", wdata, 32'h0);
    res_n = 1;

    for (int i = 0; i < 8; i++) run_txn(i);

    // Reset while AW is stalled by the slave: valids must drop at once.
    cfg_aw_d = 20; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0;
    cfg_resp = 0; cfg_sdata = 0;
    @(posedge clk); #1;
    mem_write = 1; mem_addr = 32'h0000_7000; mem_wdata = 32'h1111_2222; mem_wstrb = 4'hF;
    @(posedge clk); #1;
    mem_write = 0;
    repeat (2) @(negedge clk);
    check("pre-reset awvalid", awvalid, 1'b1);
    check("pre-reset awready", awready, 1'b0);
    #2 res_n = 0;
    #1;
    check("async reset awvalid", awvalid, 1'b0);
    check("async reset wvalid", wvalid, 1'b0);
    check("async reset bready", bready, 1'b0);
    check("async reset arvalid", arvalid, 1'b0);
    check("async reset mem_done", mem_done, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    check("held reset awvalid", awvalid, 1'b0);
    res_n = 1;
    run_txn(8);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
`default_nettype wire
